// File: rtl/saber_mem_pkg.sv
// Shared constants and types for the Saber data-memory access blocks.
package saber_mem_pkg;
  localparam int DW         = 64;
  localparam int AW         = 9;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } unload_state_t;
endpackage

// File: rtl/word_fifo.sv
// Small register FIFO with same-cycle push/pop; pointers and count are reset,
// storage is not.
module word_fifo
  import saber_mem_pkg::*;
#(
  parameter int DATA_W = saber_mem_pkg::DW,
  parameter int DEPTH  = saber_mem_pkg::FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A push into a full FIFO is only accepted when a word leaves in the same cycle.
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/word_unload.sv
// Drains a block of words from synchronous-read memory onto a valid/ready port,
// using a credit rule so the output FIFO can never overflow.
module word_unload
  import saber_mem_pkg::*;
#(
  parameter int DW    = saber_mem_pkg::DW,
  parameter int AW    = saber_mem_pkg::AW,
  parameter int DEPTH = saber_mem_pkg::FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_address,
  input  logic [AW-1:0] number_words,
  output logic [AW-1:0] read_address,
  input  logic [DW-1:0] read_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);
  localparam int CW = $clog2(DEPTH+1);

  unload_state_t state_q, state_d;
  logic [AW-1:0] base_q, last_addr_q, issue_addr;
  logic [AW:0]   count_q, issued_q, sent_q;
  logic          pending_q;
  logic          accept, issue, pop, last_word;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;

  assign accept     = start && (state_q != RUN);
  assign pop        = out_valid && out_ready;
  assign last_word  = ((sent_q + (AW+1)'(1)) == count_q);
  assign issue_addr = base_q + issued_q[AW-1:0];
  // Credit counts both buffered words and the read still in flight from memory.
  assign issue      = (state_q == RUN) && (issued_q < count_q) &&
                      ((int'(fifo_count) + int'(pending_q)) < DEPTH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (count_q == '0) state_d = DONE;
        else if (pop && last_word) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      pending_q   <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= issue;
      if (issue) last_addr_q <= issue_addr;
      if (accept) begin
        base_q   <= base_address;
        count_q  <= {1'b0, number_words};
        issued_q <= '0;
        sent_q   <= '0;
      end else if (state_q == RUN) begin
        if (issue) issued_q <= issued_q + (AW+1)'(1);
        if (pop)   sent_q   <= sent_q + (AW+1)'(1);
      end
    end
  end

  word_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pending_q),
    .push_data_i (read_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign read_address = issue ? issue_addr : last_addr_q;
  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_empty ? '0 : fifo_head;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
endmodule

// File: tb/tb_word_unload.sv
// Directed, table-driven bench for word_unload with a synchronous-read memory model.
module tb_word_unload;
  localparam int DW = 64;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_address = '0;
  logic [AW-1:0] number_words = '0;
  logic [AW-1:0] read_address;
  logic [DW-1:0] read_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [512];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] n;
    int            mode;     // 0: ready high, 1: random ready, 2: ready low then high
    bit            glitch;   // pulse start mid-run
    int            exp_done; // cycle where done first high, -1 when not cycle-exact
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[read_address];

  word_unload dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_address (base_address),
    .number_words (number_words),
    .read_address (read_address),
    .read_data    (read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int            idx = 0;
    int            done_cyc = -1;
    int            maxc = 0;
    int            stall_bad = 0;
    int            order_bad = 0;
    int            timing_bad = 0;
    int            addr_bad = 0;
    int            valid_seen = 0;
    logic          pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] addr0, a;
    addr0 = read_address;
    @(posedge clk); #1;
    start = 1'b1; base_address = v.base; number_words = v.n;
    out_ready = (v.mode == 0);
    for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = v.glitch && (cyc == 4);
      if (start) begin base_address = 9'd200; number_words = 9'd1; end
      if (v.mode == 1) out_ready = ($urandom_range(0, 9) < 3);
      if (v.mode == 2) out_ready = (cyc > 12);
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_cycle1", busy, 1);
        chk("done_cycle1", done, 0);
        if (v.n != 0) chk("addr_cycle1", read_address, v.base);
      end
      if (int'(dut.u_fifo.count_o) > maxc) maxc = int'(dut.u_fifo.count_o);
      if (v.n == 0 && read_address !== addr0) addr_bad++;
      if (v.n == 0 && out_valid) valid_seen++;
      if (pv && !pr && (!out_valid || out_data !== pd)) stall_bad++;
      if (out_valid && out_ready) begin
        a = v.base + idx[AW-1:0];
        if (out_data !== mem[a]) order_bad++;
        if (v.mode == 0 && cyc != 3 + idx) timing_bad++;
        idx++;
      end
      if (done) done_cyc = cyc;
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    chk("done_reached", (done_cyc >= 0), 1);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    chk("word_count", idx, v.n);
    chk("word_order", order_bad, 0);
    chk("fifo_le_4", (maxc <= 4), 1);
    chk("stall_stable", stall_bad, 0);
    if (v.mode == 0) chk("word_timing", timing_bad, 0);
    if (v.mode == 2) chk("fifo_fills_4", maxc, 4);
    if (v.n == 0) begin
      chk("zero_addr_hold", addr_bad, 0);
      chk("zero_no_valid", valid_seen, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'(i + 'h100);
    tbl[0] = '{9'd5,   9'd8,  0, 1'b0, 11};
    tbl[1] = '{9'd0,   9'd0,  0, 1'b0, 2};
    tbl[2] = '{9'd508, 9'd6,  0, 1'b0, 9};
    tbl[3] = '{9'd0,   9'd10, 1, 1'b0, -1};
    tbl[4] = '{9'd100, 9'd3,  0, 1'b1, 6};
    tbl[5] = '{9'd300, 9'd7,  2, 1'b0, -1};
    tbl[6] = '{9'd511, 9'd1,  0, 1'b0, 4};

    #12;
    chk("rst_read_address", read_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 7; t++) run(tbl[t]);

    // Reset in the middle of a run, after three transfers.
    @(posedge clk); #1;
    start = 1'b1; base_address = 9'd5; number_words = 9'd8; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_read_address", read_address, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    run('{9'd0, 9'd2, 0, 1'b0, 5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
